// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings and IM geometry.
package im_loader_pkg;

    localparam int unsigned IM_BYTES = 1024;
    localparam int unsigned IM_WORDS = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCEPT = 2'b01,
        WRITE  = 2'b10,
        DONE   = 2'b11
    } ld_state_t;

endpackage

// File: rtl/im_byte_serializer.sv
// Holds one accepted instruction word and presents it one byte lane at a time, lane 0 first.
module im_byte_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic        advance,
    output logic [7:0]  lane_byte,
    output logic        last_lane
);

    logic [31:0] buffer;
    logic [1:0]  lane;
    logic [1:0]  next_lane;

    assign next_lane = lane + 2'd1;
    assign last_lane = (lane == 2'd3);

    // lane_byte is registered so the memory sees a clean byte alongside mem_we
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer    <= 32'd0;
            lane      <= 2'd0;
            lane_byte <= 8'd0;
        end else if (load) begin
            buffer    <= data;
            lane      <= 2'd0;
            lane_byte <= data[7:0];
        end else if (advance) begin
            lane      <= next_lane;
            lane_byte <= buffer[{next_lane, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/im_loader.sv
// Runtime writer for the byte-addressed IM: accepts 32-bit words and writes them little-endian.
// Optional IM_LOAD_CHECKSUM_EN adds a modulo-2^32 checksum of all accepted words.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
`ifdef IM_LOAD_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic [ADDR_W-2:0] word_count
);

    ld_state_t         state;
    logic              last_flag;
    logic              accept_hs;
    logic              last_lane;
    logic [ADDR_W-2:0] count_inc;

    assign accept_hs = (state == ACCEPT) && in_valid && in_ready;
    assign count_inc = word_count + (ADDR_W-1)'(1);

    im_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_hs),
        .data      (in_data),
        .advance   ((state == WRITE) && !last_lane),
        .lane_byte (mem_wdata),
        .last_lane (last_lane)
    );

    // Word base address is derived from word_count, so the address never wraps past the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_flag  <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCEPT;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (accept_hs) begin
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        last_flag <= in_last;
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'({word_count, 2'b00});
                    end
                end
                WRITE: begin
                    if (!last_lane) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end else begin
                        mem_we     <= 1'b0;
                        word_count <= count_inc;
                        if (last_flag) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (count_inc == (ADDR_W-1)'(MAX_WORDS)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= 32'd0;
        end else if ((state == IDLE) && start) begin
            checksum <= 32'd0;
        end else if (accept_hs) begin
            checksum <= checksum + in_data;
        end
    end
`endif

endmodule
